// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller: load-use and branch-operand hazard detection,
// ID-stage compare forwarding, and multi-cycle MUL occupancy sequencing of EX.
module hazard_stall_unit #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned CNT_W       = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_cmp_rs,
    input  logic              id_cmp_rt,
    input  logic              id_is_mul,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              bubble_ex,
    output logic              bubble_mem,
    output logic [1:0]        fwd_id_a,
    output logic [1:0]        fwd_id_b,
    output logic              mul_busy
);

    localparam logic [0:0]       ST_IDLE     = 1'b0;
    localparam logic [0:0]       ST_MUL_BUSY = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic             MUL_MULTI   = (MUL_LATENCY > 1);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic ex_hit_rs, ex_hit_rt;
    logic mem_hit_rs, mem_hit_rt;
    logic wb_hit_rs, wb_hit_rt;
    logic load_use, cmp_hazard, data_stall;

    // Register 0 is hardwired, so a write to it never produces a dependency.
    function automatic logic reg_match(input logic              we,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] src);
        return we & (rd == src) & (src != '0);
    endfunction

    always_comb begin
        ex_hit_rs  = reg_match(ex_reg_write,  ex_rd,  id_rs);
        ex_hit_rt  = reg_match(ex_reg_write,  ex_rd,  id_rt);
        mem_hit_rs = reg_match(mem_reg_write, mem_rd, id_rs);
        mem_hit_rt = reg_match(mem_reg_write, mem_rd, id_rt);
        wb_hit_rs  = reg_match(wb_reg_write,  wb_rd,  id_rs);
        wb_hit_rt  = reg_match(wb_reg_write,  wb_rd,  id_rt);
    end

    // Load in EX feeding any consumer, or an ID-stage compare whose value is not yet available.
    always_comb begin
        load_use   = ex_mem_read &
                     ((ex_hit_rs & (id_use_rs | id_cmp_rs)) |
                      (ex_hit_rt & (id_use_rt | id_cmp_rt)));
        cmp_hazard = (id_cmp_rs & ((ex_hit_rs & ~ex_mem_read) | (mem_hit_rs & mem_mem_read))) |
                     (id_cmp_rt & ((ex_hit_rt & ~ex_mem_read) | (mem_hit_rt & mem_mem_read)));
        data_stall = load_use | cmp_hazard;
    end

    // MEM ALU result is newer than WB, so it wins when both match.
    always_comb begin
        fwd_id_a = FWD_RF;
        fwd_id_b = FWD_RF;
        if (mem_hit_rs & ~mem_mem_read) begin
            fwd_id_a = FWD_MEM;
        end else if (wb_hit_rs) begin
            fwd_id_a = FWD_WB;
        end
        if (mem_hit_rt & ~mem_mem_read) begin
            fwd_id_b = FWD_MEM;
        end else if (wb_hit_rt) begin
            fwd_id_b = FWD_WB;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A MUL held off by a data hazard stays in ID and is re-evaluated next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (id_is_mul & ~data_stall & MUL_MULTI) begin
                    state_d = ST_MUL_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_MUL_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // MUL occupancy overrides data hazards; everything is forced low during reset.
    always_comb begin
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        bubble_ex  = 1'b0;
        bubble_mem = 1'b0;
        mul_busy   = 1'b0;
        if (reset_n) begin
            if (state_q == ST_MUL_BUSY) begin
                stall_if   = 1'b1;
                stall_id   = 1'b1;
                stall_ex   = 1'b1;
                bubble_mem = 1'b1;
                mul_busy   = 1'b1;
            end else if (data_stall) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized and directed bench for hazard_stall_unit against a remaining-busy-cycles model.
module tb_hazard_stall_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs, id_use_rt, id_cmp_rs, id_cmp_rt, id_is_mul;
    logic       ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, wb_reg_write;

    logic       s_if4, s_id4, s_ex4, b_ex4, b_mem4, busy4;
    logic [1:0] fa4, fb4;
    logic       s_if1, s_id1, s_ex1, b_ex1, b_mem1, busy1;
    logic [1:0] fa1, fb1;

    int n_checks = 0;
    int n_pass   = 0;
    int left4    = 0;
    int left1    = 0;
    int busy4_seen = 0;
    int busy1_seen = 0;

    hazard_stall_unit #(.REG_AW(5), .MUL_LATENCY(4), .CNT_W(4)) dut4 (
        .clock(clk), .reset_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_cmp_rs(id_cmp_rs), .id_cmp_rt(id_cmp_rt), .id_is_mul(id_is_mul),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .stall_if(s_if4), .stall_id(s_id4), .stall_ex(s_ex4),
        .bubble_ex(b_ex4), .bubble_mem(b_mem4),
        .fwd_id_a(fa4), .fwd_id_b(fb4), .mul_busy(busy4)
    );

    hazard_stall_unit #(.REG_AW(5), .MUL_LATENCY(1), .CNT_W(4)) dut1 (
        .clock(clk), .reset_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_cmp_rs(id_cmp_rs), .id_cmp_rt(id_cmp_rt), .id_is_mul(id_is_mul),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .stall_if(s_if1), .stall_id(s_id1), .stall_ex(s_ex1),
        .bubble_ex(b_ex1), .bubble_mem(b_mem1),
        .fwd_id_a(fa1), .fwd_id_b(fb1), .mul_busy(busy1)
    );

    wire [9:0] got4 = {s_if4, s_id4, s_ex4, b_ex4, b_mem4, busy4, fa4, fb4};
    wire [9:0] got1 = {s_if1, s_id1, s_ex1, b_ex1, b_mem1, busy1, fa1, fb1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit dep(input logic we, input logic [4:0] rd, input logic [4:0] src);
        return we && (rd == src) && (src != 5'd0);
    endfunction

    function automatic bit hazard_now();
        bit lu, ch;
        lu = ex_mem_read &&
             ((dep(ex_reg_write, ex_rd, id_rs) && (id_use_rs || id_cmp_rs)) ||
              (dep(ex_reg_write, ex_rd, id_rt) && (id_use_rt || id_cmp_rt)));
        ch = (id_cmp_rs && ((dep(ex_reg_write, ex_rd, id_rs) && !ex_mem_read) ||
                            (dep(mem_reg_write, mem_rd, id_rs) && mem_mem_read))) ||
             (id_cmp_rt && ((dep(ex_reg_write, ex_rd, id_rt) && !ex_mem_read) ||
                            (dep(mem_reg_write, mem_rd, id_rt) && mem_mem_read)));
        return lu || ch;
    endfunction

    function automatic logic [1:0] fwd_src(input logic [4:0] src);
        if (dep(mem_reg_write, mem_rd, src) && !mem_mem_read) return 2'd1;
        if (dep(wb_reg_write, wb_rd, src)) return 2'd2;
        return 2'd0;
    endfunction

    // Expected {stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, mul_busy, fwd_a, fwd_b}.
    function automatic logic [9:0] expect_out(input int busy_left);
        logic [5:0] ctl;
        ctl = 6'b0;
        if (rst_n) begin
            if (busy_left > 0) ctl = 6'b111011;
            else if (hazard_now()) ctl = 6'b110100;
        end
        return {ctl, fwd_src(id_rs), fwd_src(id_rt)};
    endfunction

    function automatic int next_left(input int busy_left, input int lat);
        if (busy_left > 0) return busy_left - 1;
        if (id_is_mul && !hazard_now() && lat > 1) return lat - 1;
        return 0;
    endfunction

    task automatic cycle();
        #3;
        check("dut_lat4", 16'(got4), 16'(expect_out(left4)));
        check("dut_lat1", 16'(got1), 16'(expect_out(left1)));
        if (busy4 === 1'b1) busy4_seen++;
        if (busy1 === 1'b1) busy1_seen++;
        @(posedge clk);
        if (rst_n) begin
            left4 = next_left(left4, 4);
            left1 = next_left(left1, 1);
        end
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        id_use_rs = 0; id_use_rt = 0; id_cmp_rs = 0; id_cmp_rt = 0; id_is_mul = 0;
        ex_reg_write = 0; ex_mem_read = 0; mem_reg_write = 0; mem_mem_read = 0;
        wb_reg_write = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #2;
        check("reset_ctl4", 16'(got4), 16'd0);
        check("reset_ctl1", 16'(got1), 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();

        // Load-use on rs: one stall cycle, then clear
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
        #1;
        check("loaduse_ctl", 16'(got4), 16'b11_0100_0000);
        cycle();
        clear_inputs();
        cycle();

        // Branch compare forwarding from MEM, then WB
        id_cmp_rt = 1; id_rt = 8; mem_rd = 8; mem_reg_write = 1;
        #1;
        check("fwd_mem", 16'(got4), 16'b00_0000_0001);
        cycle();
        mem_reg_write = 0; wb_rd = 8; wb_reg_write = 1;
        #1;
        check("fwd_wb", 16'(got4), 16'b00_0000_0010);
        cycle();
        clear_inputs();

        // Register zero never creates a dependency
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1; id_cmp_rs = 1;
        mem_reg_write = 1; mem_rd = 0; wb_reg_write = 1; wb_rd = 0;
        #1;
        check("reg_zero", 16'(got4), 16'd0);
        cycle();
        clear_inputs();

        // MUL occupancy: 3 busy cycles at latency 4, none at latency 1
        id_is_mul = 1;
        busy4_seen = 0; busy1_seen = 0;
        cycle();
        id_is_mul = 0;
        repeat (6) cycle();
        check("mul4_busy_cycles", 16'(busy4_seen), 16'd3);
        check("mul1_busy_cycles", 16'(busy1_seen), 16'd0);

        // MUL held off by load-use, launches once the hazard clears
        id_is_mul = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3; id_rs = 3; id_use_rs = 1;
        cycle();
        check("mul_held_busy", 16'(busy4), 16'd0);
        check("mul_held_stall", 16'({s_if4, b_ex4}), 16'b11);
        ex_mem_read = 0; ex_reg_write = 0;
        cycle();
        id_is_mul = 0;
        #1;
        check("mul_launch_after_hazard", 16'(busy4), 16'd1);
        repeat (4) cycle();

        // Reset mid-MUL aborts at once; a fresh MUL gets the full occupancy
        id_is_mul = 1;
        cycle();
        id_is_mul = 0;
        cycle();
        rst_n = 1'b0;
        left4 = 0; left1 = 0;
        #1;
        check("reset_mid_mul", 16'(got4[9:4]), 16'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        check("after_reset_idle", 16'(busy4), 16'd0);
        id_is_mul = 1;
        busy4_seen = 0;
        cycle();
        id_is_mul = 0;
        repeat (6) cycle();
        check("mul_after_reset", 16'(busy4_seen), 16'd3);

        // Randomized traffic over a small register set to make matches common
        busy1_seen = 0;
        for (int i = 0; i < 400; i++) begin
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            id_cmp_rs = 1'($urandom); id_cmp_rt = 1'($urandom);
            id_is_mul = ($urandom_range(0, 4) == 0);
            ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
            mem_reg_write = 1'($urandom); mem_mem_read = 1'($urandom);
            wb_reg_write = 1'($urandom);
            cycle();
        end
        check("rand_mul1_never_busy", 16'(busy1_seen), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
